// File: rtl/gen_wave_pkg.sv
// rtl/gen_wave_pkg.sv - shared state encoding and widths for the wave sweep sequencer
package gen_wave_pkg;

  localparam int SWEEP_PHASE_W = 10;
  localparam int SWEEP_DWELL_W = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    STEP  = 2'd2,
    DONE  = 2'd3
  } sweep_state_e;

endpackage

// File: rtl/sweep_dwell_timer.sv
// rtl/sweep_dwell_timer.sv - loadable down-counter that flags when the dwell interval has elapsed
import gen_wave_pkg::*;

module sweep_dwell_timer #(
  parameter int SIZE_DWELL = SWEEP_DWELL_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic [SIZE_DWELL-1:0] i_value,
  input  logic                  i_dec,
  output logic                  o_expired
);

  logic [SIZE_DWELL-1:0] r_count;

  localparam logic [SIZE_DWELL-1:0] COUNT_ONE = SIZE_DWELL'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - COUNT_ONE;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/wave_sweep_ctrl.sv
// rtl/wave_sweep_ctrl.sv - NCO phase-step sweep sequencer (start..stop by inc, dwell per step)
// Optional triangle sweep when SWEEP_PINGPONG_EN is defined; default build is sawtooth only.
import gen_wave_pkg::*;

module wave_sweep_ctrl #(
  parameter int SIZE_PHASE = SWEEP_PHASE_W,
  parameter int SIZE_DWELL = SWEEP_DWELL_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_cont,
  input  logic [SIZE_PHASE-1:0] i_start_step,
  input  logic [SIZE_PHASE-1:0] i_stop_step,
  input  logic [SIZE_PHASE-1:0] i_inc,
  input  logic [SIZE_DWELL-1:0] i_dwell,
  output logic [SIZE_PHASE-1:0] o_phase_step,
  output logic                  o_step_stb,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [1:0]            o_state
);

  localparam logic [SIZE_PHASE-1:0] PHASE_ONE = SIZE_PHASE'(1);
  localparam logic [SIZE_DWELL-1:0] DWELL_ONE = SIZE_DWELL'(1);

  sweep_state_e          r_state;
  sweep_state_e          w_state_nxt;

  logic [SIZE_PHASE-1:0] r_start;
  logic [SIZE_PHASE-1:0] r_stop;
  logic [SIZE_PHASE-1:0] r_inc;
  logic [SIZE_DWELL-1:0] r_dwell;
  logic                  r_cont;

  logic [SIZE_PHASE-1:0] r_phase;
  logic                  r_stb;
  logic [SIZE_PHASE-1:0] w_phase_nxt;
  logic                  w_stb_nxt;

  logic                  w_accept;
  logic [SIZE_PHASE-1:0] w_inc_in;
  logic [SIZE_DWELL-1:0] w_dwell_in;

  logic                  w_load;
  logic [SIZE_DWELL-1:0] w_load_val;
  logic                  w_dec;
  logic                  w_expired;

  logic [SIZE_PHASE:0]   w_sum;
  logic [SIZE_PHASE:0]   w_diff;
  logic [SIZE_PHASE-1:0] w_up_sat;
  logic [SIZE_PHASE-1:0] w_dn_sat;
  logic                  w_at_stop;
  logic                  w_at_start;

`ifdef SWEEP_PINGPONG_EN
  logic r_dir_dn;
  logic w_dir_dn_nxt;
`endif

  // Zero increment or dwell would stall the sweep, so both are promoted to 1.
  assign w_inc_in   = (i_inc == '0) ? PHASE_ONE : i_inc;
  assign w_dwell_in = (i_dwell == '0) ? DWELL_ONE : i_dwell;
  assign w_accept   = (r_state == IDLE) && i_start && !i_stop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_start <= '0;
      r_stop  <= '0;
      r_inc   <= PHASE_ONE;
      r_dwell <= DWELL_ONE;
      r_cont  <= 1'b0;
    end else if (w_accept) begin
      r_start <= i_start_step;
      r_stop  <= i_stop_step;
      r_inc   <= w_inc_in;
      r_dwell <= w_dwell_in;
      r_cont  <= i_cont;
    end
  end

  // One extra bit keeps the sum/difference from wrapping before saturation.
  assign w_sum      = {1'b0, r_phase} + {1'b0, r_inc};
  assign w_diff     = {1'b0, r_phase} - {1'b0, r_inc};
  assign w_up_sat   = (w_sum > {1'b0, r_stop}) ? r_stop : w_sum[SIZE_PHASE-1:0];
  assign w_dn_sat   = (w_diff[SIZE_PHASE] || (w_diff[SIZE_PHASE-1:0] < r_start)) ?
                      r_start : w_diff[SIZE_PHASE-1:0];
  assign w_at_stop  = (r_phase >= r_stop);
  assign w_at_start = (r_phase <= r_start);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_stb_nxt   = 1'b0;
    w_load      = 1'b0;
    w_load_val  = r_dwell - DWELL_ONE;
    w_dec       = 1'b0;
`ifdef SWEEP_PINGPONG_EN
    w_dir_dn_nxt = r_dir_dn;
`endif
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = DWELL;
          w_phase_nxt = i_start_step;
          w_stb_nxt   = 1'b1;
          w_load      = 1'b1;
          w_load_val  = w_dwell_in - DWELL_ONE;
`ifdef SWEEP_PINGPONG_EN
          w_dir_dn_nxt = 1'b0;
`endif
        end
      end
      DWELL: begin
        if (i_stop) begin
          w_state_nxt = IDLE;
        end else if (w_expired) begin
          w_state_nxt = STEP;
        end else begin
          w_dec = 1'b1;
        end
      end
      STEP: begin
        if (i_stop) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DWELL;
          w_stb_nxt   = 1'b1;
          w_load      = 1'b1;
`ifdef SWEEP_PINGPONG_EN
          if (!r_dir_dn) begin
            if (w_at_stop) begin
              w_dir_dn_nxt = 1'b1;
              w_phase_nxt  = w_dn_sat;
            end else begin
              w_phase_nxt = w_up_sat;
            end
          end else if (w_at_start) begin
            if (r_cont) begin
              w_dir_dn_nxt = 1'b0;
              w_phase_nxt  = w_up_sat;
            end else begin
              w_state_nxt = DONE;
              w_stb_nxt   = 1'b0;
              w_load      = 1'b0;
            end
          end else begin
            w_phase_nxt = w_dn_sat;
          end
`else
          if (w_at_stop) begin
            if (r_cont) begin
              w_phase_nxt = r_start;
            end else begin
              w_state_nxt = DONE;
              w_stb_nxt   = 1'b0;
              w_load      = 1'b0;
            end
          end else begin
            w_phase_nxt = w_up_sat;
          end
`endif
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= '0;
      r_stb   <= 1'b0;
    end else begin
      r_phase <= w_phase_nxt;
      r_stb   <= w_stb_nxt;
    end
  end

`ifdef SWEEP_PINGPONG_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dir_dn <= 1'b0;
    end else begin
      r_dir_dn <= w_dir_dn_nxt;
    end
  end
`endif

  sweep_dwell_timer #(
    .SIZE_DWELL (SIZE_DWELL)
  ) u_dwell_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (w_load),
    .i_value   (w_load_val),
    .i_dec     (w_dec),
    .o_expired (w_expired)
  );

  assign o_phase_step = r_phase;
  assign o_step_stb   = r_stb;
  assign o_busy       = (r_state != IDLE);
  assign o_done       = (r_state == DONE);
  assign o_state      = r_state;

endmodule

// File: tb/tb_wave_sweep_ctrl.sv
// tb/tb_wave_sweep_ctrl.sv - scoreboard bench for wave_sweep_ctrl (strobed phase values, dwell gaps, done)
module tb_wave_sweep_ctrl;

  localparam int W = 10;
  localparam int D = 24;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic         i_stop = 1'b0;
  logic         i_cont = 1'b0;
  logic [W-1:0] i_start_step = '0;
  logic [W-1:0] i_stop_step = '0;
  logic [W-1:0] i_inc = '0;
  logic [D-1:0] i_dwell = '0;
  logic [W-1:0] o_phase_step;
  logic         o_step_stb;
  logic         o_busy;
  logic         o_done;
  logic [1:0]   o_state;

  wave_sweep_ctrl #(.SIZE_PHASE(W), .SIZE_DWELL(D)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .i_cont       (i_cont),
    .i_start_step (i_start_step),
    .i_stop_step  (i_stop_step),
    .i_inc        (i_inc),
    .i_dwell      (i_dwell),
    .o_phase_step (o_phase_step),
    .o_step_stb   (o_step_stb),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_state      (o_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] phase;
    int           gap;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_stb_cyc = 0;
  int   done_cnt = 0;
  int   exp_done_gap = 0;

  always @(posedge clk) cyc++;

  // Monitor: every strobe must match the next expected value and its dwell spacing.
  always @(negedge clk) begin
    if (rst_n && o_step_stb) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe actual_phase=%0d required=no_strobe", o_phase_step);
      end else begin
        mon_e = exp_q.pop_front();
        if (o_phase_step !== mon_e.phase) begin
          errors++;
          $display("FAIL strobe_phase actual=%0d required=%0d", o_phase_step, mon_e.phase);
        end
        if (mon_e.gap != 0) begin
          checks++;
          if (cyc - last_stb_cyc != mon_e.gap) begin
            errors++;
            $display("FAIL dwell_gap phase=%0d actual=%0d required=%0d",
                     mon_e.phase, cyc - last_stb_cyc, mon_e.gap);
          end
        end
      end
      last_stb_cyc = cyc;
    end
    if (rst_n && o_done) begin
      done_cnt++;
      checks++;
      if (cyc - last_stb_cyc != exp_done_gap) begin
        errors++;
        $display("FAIL done_gap actual=%0d required=%0d", cyc - last_stb_cyc, exp_done_gap);
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input logic [W-1:0] p, input int g);
    exp_t e;
    e.phase = p;
    e.gap   = g;
    exp_q.push_back(e);
  endtask

  task automatic start_sweep(input int s, input int e, input int inc, input int dw, input logic cont);
    @(negedge clk);
    i_start_step = W'(s);
    i_stop_step  = W'(e);
    i_inc        = W'(inc);
    i_dwell      = D'(dw);
    i_cont       = cont;
    i_start      = 1'b1;
    @(negedge clk);
    i_start      = 1'b0;
  endtask

  task automatic wait_idle(output int maxp);
    maxp = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (int'(o_phase_step) > maxp) maxp = int'(o_phase_step);
      if (!o_busy && exp_q.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout_idle actual=busy required=idle");
  endtask

  int maxp;
  int dbase;
  bit seen;

  initial begin
    // Reset values
    #1;
    check("rst_phase", int'(o_phase_step), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_stb", int'(o_step_stb), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_state", int'(o_state), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single pass 10..40 step 10, dwell 3; a mid-sweep restart attempt with new config is ignored
    dbase = done_cnt;
    exp_done_gap = 4;
    push(10, 0); push(20, 4); push(30, 4); push(40, 4);
    start_sweep(10, 40, 10, 3, 1'b0);
    @(negedge clk);
    i_start_step = 200;
    i_stop_step  = 300;
    i_inc        = 50;
    i_start      = 1'b1;
    @(negedge clk);
    i_start      = 1'b0;
    wait_idle(maxp);
    check("t1_done_count", done_cnt - dbase, 1);
    check("t1_final_phase", int'(o_phase_step), 40);
    check("t1_busy", int'(o_busy), 0);

    // Saturation at the stop value
    dbase = done_cnt;
    exp_done_gap = 3;
    push(100, 0); push(104, 3); push(105, 3);
    start_sweep(100, 105, 4, 2, 1'b0);
    wait_idle(maxp);
    check("t2_max_phase", maxp, 105);
    check("t2_done_count", done_cnt - dbase, 1);
    check("t2_final_phase", int'(o_phase_step), 105);

    // Continuous sweep then abort
    dbase = done_cnt;
    push(1, 0); push(2, 2); push(3, 2); push(1, 2); push(2, 2); push(3, 2); push(1, 2);
    start_sweep(1, 3, 1, 1, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        seen = 1'b1;
        break;
      end
    end
    check("t3_cont_drained", int'(seen), 1);
    i_stop = 1'b1;
    @(posedge clk);
    #1;
    i_stop = 1'b0;
    check("t3_stop_state", int'(o_state), 0);
    check("t3_stop_busy", int'(o_busy), 0);
    check("t3_stop_phase", int'(o_phase_step), 1);
    repeat (4) @(negedge clk);
    check("t3_no_done", done_cnt - dbase, 0);

    // Start and stop together from IDLE: stop wins
    @(negedge clk);
    i_start_step = 7;
    i_start = 1'b1;
    i_stop  = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_stop  = 1'b0;
    check("t4_state", int'(o_state), 0);
    check("t4_busy", int'(o_busy), 0);
    repeat (3) @(negedge clk);
    check("t4_phase_held", int'(o_phase_step), 1);

    // Zero dwell and zero increment behave as 1
    dbase = done_cnt;
    exp_done_gap = 2;
    push(5, 0); push(6, 2); push(7, 2); push(8, 2);
    start_sweep(5, 8, 0, 0, 1'b0);
    wait_idle(maxp);
    check("t5_done_count", done_cnt - dbase, 1);
    check("t5_final_phase", int'(o_phase_step), 8);

    // Triangle (optional) or sawtooth single pass 2..4
    dbase = done_cnt;
    exp_done_gap = 2;
`ifdef SWEEP_PINGPONG_EN
    push(2, 0); push(3, 2); push(4, 2); push(3, 2); push(2, 2);
    start_sweep(2, 4, 1, 1, 1'b0);
    wait_idle(maxp);
    check("t6_final_phase", int'(o_phase_step), 2);
`else
    push(2, 0); push(3, 2); push(4, 2);
    start_sweep(2, 4, 1, 1, 1'b0);
    wait_idle(maxp);
    check("t6_final_phase", int'(o_phase_step), 4);
`endif
    check("t6_done_count", done_cnt - dbase, 1);

    // Asynchronous reset mid-DWELL
    push(50, 0);
    start_sweep(50, 60, 1, 10, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t7_rst_phase", int'(o_phase_step), 0);
    check("t7_rst_busy", int'(o_busy), 0);
    check("t7_rst_stb", int'(o_step_stb), 0);
    check("t7_rst_state", int'(o_state), 0);
    check("t7_rst_done", int'(o_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t7_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
